// File: rtl/fft_stage_scheduler.sv
// Address/strobe sequencer for an in-place radix-2 FFT over N=2**LOG_N points through a single
// butterfly pipeline, with write-back addresses delayed to line up with the pipeline's done strobe.
module fft_stage_scheduler #(
    parameter int unsigned LOG_N    = 3,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         issue_ok,
    input  logic                         bf_done,
    output logic                         rd_en,
    output logic [LOG_N-1:0]             rd_addr_a,
    output logic [LOG_N-1:0]             rd_addr_b,
    output logic [LOG_N-2:0]             tw_addr,
    output logic                         bf_start,
    output logic                         wr_en,
    output logic [LOG_N-1:0]             wr_addr_a,
    output logic [LOG_N-1:0]             wr_addr_b,
    output logic [$clog2(LOG_N+1)-1:0]   stage,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned KW  = LOG_N - 1;
    localparam int unsigned SW  = $clog2(LOG_N + 1);
    localparam int unsigned DLY = RD_LAT + PIPE_LAT;
    localparam int unsigned CW  = $clog2(DLY + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [CW-1:0]     infl_q, infl_d;
    logic              err_q, err_d;

    logic [LOG_N-1:0]  ra_q, rb_q, wa_q, wb_q;
    logic [KW-1:0]     tw_q;

    logic [RD_LAT-1:0]            bs_q;
    logic [DLY-1:0]               den_q;
    logic [DLY-1:0][LOG_N-1:0]    da_q, db_q;

    logic [KW-1:0]     mask, off, tw_calc;
    logic [LOG_N-1:0]  a_calc, b_calc, span;
    logic              start_acc;

    // mask = span-1 where span = N >> (stage+1); group base is k with the offset bits cleared,
    // shifted up one to skip the partner half of each group.
    always_comb begin
        mask    = {KW{1'b1}} >> stage_q;
        off     = k_q & mask;
        a_calc  = {k_q & ~mask, 1'b0} | {1'b0, off};
        span    = {1'b0, mask} + LOG_N'(1);
        b_calc  = a_calc + span;
        tw_calc = off << stage_q;
    end

    assign rd_en     = (state_q == StIssue) && issue_ok;
    assign wr_en     = den_q[DLY-1];
    assign bf_start  = bs_q[RD_LAT-1];
    assign start_acc = (state_q == StIdle) && start;

    assign rd_addr_a = rd_en ? a_calc : ra_q;
    assign rd_addr_b = rd_en ? b_calc : rb_q;
    assign tw_addr   = rd_en ? tw_calc : tw_q;
    assign wr_addr_a = wr_en ? da_q[DLY-1] : wa_q;
    assign wr_addr_b = wr_en ? db_q[DLY-1] : wb_q;
    assign stage     = stage_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            StIssue: begin
                if (rd_en) begin
                    k_d = k_q + KW'(1);
                    if (&k_q) state_d = StDrain;
                end
            end
            StDrain: begin
                // Last write of the stage: nothing else in flight once this one retires.
                if (wr_en && infl_q == CW'(1)) begin
                    if (stage_q == SW'(LOG_N - 1)) begin
                        state_d = StFin;
                    end else begin
                        state_d = StIssue;
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        infl_d = infl_q + CW'(rd_en) - CW'(wr_en);
        err_d  = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (wr_en != bf_done) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            stage_q <= '0;
            infl_q  <= '0;
            err_q   <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            bs_q    <= '0;
            den_q   <= '0;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            infl_q  <= infl_d;
            err_q   <= err_d;
            if (rd_en) begin
                ra_q <= a_calc;
                rb_q <= b_calc;
                tw_q <= tw_calc;
            end
            if (wr_en) begin
                wa_q <= da_q[DLY-1];
                wb_q <= db_q[DLY-1];
            end
            bs_q[0] <= rd_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                bs_q[i] <= bs_q[i-1];
            end
            den_q[0] <= rd_en;
            da_q[0]  <= a_calc;
            db_q[0]  <= b_calc;
            for (int i = 1; i < int'(DLY); i++) begin
                den_q[i] <= den_q[i-1];
                da_q[i]  <= da_q[i-1];
                db_q[i]  <= db_q[i-1];
            end
        end
    end

endmodule
